// File: rtl/sram_stream_reader.sv
// sram_stream_reader: sequential single-SRAM read initiator streaming through a 2-entry skid FIFO; define SRAM_STREAM_PERF_EN for the stall counter
module sram_stream_reader #(
  parameter int NUM_SRAMS      = 4,
  parameter int MAX_ADDR_WIDTH = 12,
  parameter int SRAM_WIDTH_O   = 64,
  parameter int SEL_W          = NUM_SRAMS > 1 ? $clog2(NUM_SRAMS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [SEL_W-1:0]                     sram_sel,
  input  logic [MAX_ADDR_WIDTH-1:0]            base_addr,
  input  logic [MAX_ADDR_WIDTH:0]              len,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic [NUM_SRAMS-1:0]                 en,
  output logic [NUM_SRAMS-1:0]                 we,
  output logic [NUM_SRAMS*MAX_ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_SRAMS*SRAM_WIDTH_O-1:0]    data_out,
  output logic [SRAM_WIDTH_O-1:0]              m_tdata,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic                                 m_tlast,
  output logic [31:0]                          perf_stall_cnt
);
  localparam int AW = MAX_ADDR_WIDTH;
  localparam int DW = SRAM_WIDTH_O;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [SEL_W-1:0] sel_q, cur_sel;
  logic [AW-1:0] base_q, cur_addr;
  logic [AW:0] len_q, issued;
  logic inflight, inflight_last;
  logic [DW-1:0] fifo_data [2];
  logic [1:0] fifo_last;
  logic rd_ptr, wr_ptr;
  logic [1:0] count;
  logic [2:0] credit;
  logic [DW-1:0] rd_data;
  logic idle, sel_ok, accept, pop, fire, fire_last;
  assign we = '0;
  assign m_tvalid = count != 2'd0;
  assign m_tdata = fifo_data[rd_ptr];
  assign m_tlast = m_tvalid && fifo_last[rd_ptr];
  always_comb begin
    idle = state == IDLE;
    sel_ok = int'(sram_sel) < NUM_SRAMS;
    accept = idle && start && sel_ok && len != '0;
    pop = m_tvalid && m_tready;
    credit = 3'(count) + 3'(inflight);
    fire = accept || (state == RUN && issued < len_q && credit < 3'd2 + 3'(pop));
    fire_last = idle ? len == {{AW{1'b0}}, 1'b1} : issued == len_q - 1'b1;
    cur_sel = idle ? sram_sel : sel_q;
    cur_addr = idle ? base_addr : base_q + issued[AW-1:0];
    rd_data = '0;
    for (int i = 0; i < NUM_SRAMS; i++) begin
      en[i] = fire && cur_sel == SEL_W'(i);
      addr[i*AW +: AW] = en[i] ? cur_addr : '0;
      rd_data = sel_q == SEL_W'(i) ? data_out[i*DW +: DW] : rd_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      sel_q <= '0;
      base_q <= '0;
      len_q <= '0;
      issued <= '0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      inflight <= fire;
      inflight_last <= fire && fire_last;
      if (fire) issued <= idle ? {{AW{1'b0}}, 1'b1} : issued + 1'b1;
      if (inflight) begin
        fifo_data[wr_ptr] <= rd_data;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + 2'(inflight) - 2'(pop);
      case (state)
        IDLE: if (start) begin
          done <= !accept;
          err <= !sel_ok;
          busy <= accept;
          if (accept) begin
            sel_q <= sram_sel;
            base_q <= base_addr;
            len_q <= len;
            state <= fire_last ? DRAIN : RUN;
          end
        end
        RUN: if (fire && fire_last) state <= DRAIN;
        DRAIN: if (pop && m_tlast) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(inflight && !pop && count == 2'd2));
      assert (credit <= 3'd2);
    end
  end
`ifdef SRAM_STREAM_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst || (idle && start)) stall_q <= '0;
    else if (m_tvalid && !m_tready && stall_q != '1) stall_q <= stall_q + 1'b1;
  end
  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_sram_stream_reader.sv
// tb_sram_stream_reader: randomized self-checking bench with a bank model and queue-based expected stream
module tb_sram_stream_reader;
  localparam int NS = 5, AW = 12, DW = 64, SW = 3;
  logic clk = 1'b0, rst, start, busy, done, err, m_tvalid, m_tready, m_tlast;
  logic [SW-1:0] sram_sel;
  logic [AW-1:0] base_addr;
  logic [AW:0] len;
  logic [NS-1:0] en, we;
  logic [NS*AW-1:0] addr;
  logic [NS*DW-1:0] data_out;
  logic [DW-1:0] m_tdata;
  logic [31:0] perf_stall_cnt;
  sram_stream_reader #(.NUM_SRAMS(NS), .MAX_ADDR_WIDTH(AW), .SRAM_WIDTH_O(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .sram_sel(sram_sel), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .err(err), .en(en), .we(we), .addr(addr), .data_out(data_out),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .perf_stall_cnt(perf_stall_cnt)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] mem [NS][4096];
  always @(posedge clk)
    for (int s = 0; s < NS; s++)
      if (en[s] && !we[s]) data_out[s*DW +: DW] <= mem[s][addr[s*AW +: AW]];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int done_cnt, err_cnt, beats, stalls, first_v, first_b, last_b, done_cyc, n_iss, n_acc, exp_sel;
  logic [DW:0] exp_q[$];
  logic [AW-1:0] addr_q[$];
  bit stalled;
  logic [DW:0] held;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      logic [NS-1:0] one;
      logic [NS*AW-1:0] exp_bus;
      check("outstanding_le2", 1'(n_iss - n_acc <= 2), 1);
      if (en != '0) begin
        one = 1;
        check("en_onehot_sel", en, one << exp_sel);
        check("read_expected", 1'(addr_q.size() != 0), 1);
        if (addr_q.size() != 0) begin
          exp_bus = '0;
          exp_bus[exp_sel*AW +: AW] = addr_q.pop_front();
          check("addr", addr, exp_bus);
        end
        n_iss++;
      end
      if (m_tvalid && m_tready) begin
        check("beat_expected", 1'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("beat", {m_tlast, m_tdata}, exp_q.pop_front());
        if (first_b < 0) first_b = cyc;
        last_b = cyc;
        n_acc++;
        beats++;
      end
      if (stalled) check("hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, held});
      stalled = m_tvalid && !m_tready;
      held = {m_tlast, m_tdata};
      if (stalled) stalls++;
      if (m_tvalid && first_v < 0) first_v = cyc;
      if (err) check("err_with_done", done, 1);
      if (done) begin
        done_cnt++;
        err_cnt += int'(err);
        done_cyc = cyc;
        check("busy_low_at_done", busy, 0);
      end
    end
  end
  function automatic logic ready_pat(input int mode, input int i);
    return mode == 0 ? 1'b1 : mode == 1 ? 1'(i % 3 == 0) : 1'($urandom_range(0, 1));
  endfunction
  task automatic step(input int mode, input int i);
    @(posedge clk);
    #1;
    m_tready = ready_pat(mode, i);
  endtask
  task automatic prep(input int sel, input int base, input int n);
    logic [AW-1:0] a;
    exp_q.delete();
    addr_q.delete();
    exp_sel = sel;
    if (sel < NS)
      for (int i = 0; i < n; i++) begin
        a = AW'(base + i);
        addr_q.push_back(a);
        exp_q.push_back({1'(i == n - 1), mem[sel][a]});
      end
    done_cnt = 0; err_cnt = 0; beats = 0; stalls = 0; first_v = -1; first_b = -1;
    start = 1'b1;
    sram_sel = SW'(sel);
    base_addr = AW'(base);
    len = (AW+1)'(n);
  endtask
  task automatic reset_check();
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_en_we", {en, we}, 0);
    check("rst_addr", addr, 0);
    check("rst_valid_last", {m_tvalid, m_tlast}, 0);
    check("rst_data", m_tdata, 0);
    check("rst_perf", perf_stall_cnt, 0);
  endtask
  task automatic run_job(input int sel, input int base, input int n, input int mode, input bit mid);
    bit ok = sel < NS && n > 0;
    int s_cyc;
    prep(sel, base, n);
    m_tready = ready_pat(mode, 0);
    step(mode, 1);
    s_cyc = cyc;
    start = 1'b0;
    sram_sel = SW'($urandom);
    base_addr = AW'($urandom);
    len = (AW+1)'($urandom);
    for (int i = 2; i < 600 && done_cnt == 0; i++) begin
      if (mid && i == 2) begin
        start = 1'b1;
        sram_sel = 0;
        len = 5;
      end
      step(mode, i);
      start = 1'b0;
    end
    for (int i = 0; i < 5; i++) step(0, i);
    check("done_count", done_cnt, 1);
    check("err_count", err_cnt, sel >= NS ? 1 : 0);
    check("beat_count", beats, ok ? n : 0);
    check("queue_empty", exp_q.size() + addr_q.size(), 0);
    check("busy_after", busy, 0);
    if (ok) begin
      check("first_valid_lat", first_v - s_cyc + 1, 2);
      check("done_after_last", done_cyc - last_b, 1);
      if (mode == 0) check("throughput", last_b - first_b, n - 1);
    end else begin
      check("done_lat", done_cyc - s_cyc + 1, 1);
      check("no_valid", 1'(first_v < 0), 1);
    end
`ifdef SRAM_STREAM_PERF_EN
    check("perf", perf_stall_cnt, stalls);
`else
    check("perf", perf_stall_cnt, 0);
`endif
  endtask
  initial begin
    for (int s = 0; s < NS; s++)
      for (int a = 0; a < 4096; a++) mem[s][a] = {$urandom, $urandom};
    data_out = '0;
    rst = 1'b1; start = 1'b0; sram_sel = '0; base_addr = '0; len = '0; m_tready = 1'b0;
    n_iss = 0; n_acc = 0; stalled = 0; exp_sel = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    reset_check();
    run_job(1, 'h010, 4, 0, 0);
    run_job(1, 'h010, 4, 1, 0);
    run_job($urandom_range(0, NS - 1), 'hFFE, 4, 2, 0);
    run_job(2, 'h123, 0, 0, 0);
    run_job(5, 'h040, 3, 0, 0);
    for (int k = 0; k < 6; k++)
      run_job($urandom_range(0, NS - 1), $urandom_range(0, 4095), $urandom_range(1, 20), $urandom_range(0, 2), 0);
    prep(2, $urandom_range(0, 4095), 8);
    m_tready = 1'b1;
    step(0, 0);
    start = 1'b0;
    for (int i = 0; i < 50 && beats < 3; i++) step(0, i);
    check("beats_before_rst", beats, 3);
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    n_iss = 0; n_acc = 0; stalled = 0; done_cnt = 0; beats = 0;
    step(0, 0);
    rst = 1'b0;
    reset_check();
    for (int i = 0; i < 10; i++) step(0, i);
    check("no_done_after_rst", done_cnt, 0);
    check("no_beats_after_rst", beats, 0);
    run_job(3, $urandom_range(0, 4095), 2, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
